// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared types and constants for the dm arbiter
package dm_arbiter_pkg;

    // Owner of the data memory: CPU is the reset/park owner.
    typedef enum logic {
        DM_ARB_CPU = 1'b0,
        DM_ARB_EXT = 1'b1
    } dm_arb_state_e;

    localparam int WORD_STEP = 4;
    localparam int LEN_W     = 4;
    localparam int WAIT_W    = 8;

    // One dm access as seen at the memory port.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic        re;
    } dm_cmd_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - CPU, external master and dm signal bundle for the arbiter
interface dm_arbiter_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;

    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [3:0]  ext_be;
    logic [3:0]  ext_len;
    logic        ext_ack;
    logic        ext_last;
    logic [31:0] ext_rdata;

    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_we;
    logic        dm_re;
    logic [31:0] dm_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_stall, cpu_rdata,
        input  ext_req, ext_we, ext_addr, ext_wdata, ext_be, ext_len,
        output ext_ack, ext_last, ext_rdata,
        output dm_addr, dm_wdata, dm_be, dm_we, dm_re,
        input  dm_rdata
    );

    // Environment side: CPU pipeline, external master and the memory.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_stall, cpu_rdata,
        output ext_req, ext_we, ext_addr, ext_wdata, ext_be, ext_len,
        input  ext_ack, ext_last, ext_rdata,
        input  dm_addr, dm_wdata, dm_be, dm_we, dm_re,
        output dm_rdata
    );

endinterface

// File: rtl/dm_arbiter_port_mux.sv
// rtl/dm_arbiter_port_mux.sv - 2:1 mux of the dm access fields selected by owner
module dm_port_mux
    import dm_arbiter_pkg::*;
(
    input  logic    sel_ext,
    input  dm_cmd_t cpu_cmd,
    input  dm_cmd_t ext_cmd,
    output dm_cmd_t dm_cmd
);

    // Pure combinational select; no state lives here.
    assign dm_cmd = sel_ext ? ext_cmd : cpu_cmd;

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - dm owner arbiter (CPU parked, external bursts via DM_ARB_BURST_EN)
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int EXT_MAX_WAIT = 8
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);

    localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(EXT_MAX_WAIT);

    dm_arb_state_e     state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic              last_beat;
    logic              ext_ack;
`ifdef DM_ARB_BURST_EN
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
`else
    logic              unused_len;
    assign unused_len = ^bus.ext_len;
`endif

    dm_cmd_t cpu_cmd, ext_cmd, dm_cmd;

    // Owner register and burst bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= DM_ARB_CPU;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
`ifdef DM_ARB_BURST_EN
            beat_q     <= '0;
            len_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
`ifdef DM_ARB_BURST_EN
            beat_q     <= beat_d;
            len_q      <= len_d;
`endif
        end
    end

    // Grant decision, anti-starvation counter and per-beat advance.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
`ifdef DM_ARB_BURST_EN
        beat_d     = beat_q;
        len_d      = len_q;
        last_beat  = (beat_q == len_q);
`else
        last_beat  = 1'b1;
`endif
        ext_ack       = 1'b0;
        bus.cpu_stall = 1'b0;

        case (state_q)
            DM_ARB_CPU: begin
                if (bus.ext_req && (!bus.cpu_req || wait_cnt_q == MAX_WAIT)) begin
                    state_d    = DM_ARB_EXT;
                    addr_d     = bus.ext_addr;
                    we_d       = bus.ext_we;
                    wait_cnt_d = '0;
`ifdef DM_ARB_BURST_EN
                    beat_d     = '0;
                    len_d      = bus.ext_len;
`endif
                end else if (!bus.ext_req) begin
                    wait_cnt_d = '0;
                end else if (bus.cpu_req && wait_cnt_q != MAX_WAIT) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DM_ARB_EXT: begin
                bus.cpu_stall = bus.cpu_req;
                wait_cnt_d    = '0;
                // A dropped request aborts the burst without performing a beat.
                ext_ack       = bus.ext_req;
                if (!bus.ext_req || last_beat) begin
                    state_d = DM_ARB_CPU;
                end
`ifdef DM_ARB_BURST_EN
                if (bus.ext_req) begin
                    addr_d = addr_q + 32'(WORD_STEP);
                    beat_d = beat_q + 1'b1;
                end
`endif
            end
            default: state_d = DM_ARB_CPU;
        endcase
    end

    assign bus.ext_ack  = ext_ack;
    assign bus.ext_last = ext_ack & last_beat;

    assign cpu_cmd = '{addr:  bus.cpu_addr,
                       wdata: bus.cpu_wdata,
                       be:    bus.cpu_be,
                       we:    bus.cpu_req & bus.cpu_we,
                       re:    bus.cpu_req & ~bus.cpu_we};

    assign ext_cmd = '{addr:  addr_q,
                       wdata: bus.ext_wdata,
                       be:    bus.ext_be,
                       we:    bus.ext_req & we_q,
                       re:    bus.ext_req & ~we_q};

    dm_port_mux u_port_mux (
        .sel_ext (state_q == DM_ARB_EXT),
        .cpu_cmd (cpu_cmd),
        .ext_cmd (ext_cmd),
        .dm_cmd  (dm_cmd)
    );

    // Strobes are held off while reset is asserted so no stray write lands.
    assign bus.dm_addr   = dm_cmd.addr;
    assign bus.dm_wdata  = dm_cmd.wdata;
    assign bus.dm_be     = dm_cmd.be;
    assign bus.dm_we     = dm_cmd.we & reset;
    assign bus.dm_re     = dm_cmd.re & reset;
    assign bus.cpu_rdata = bus.dm_rdata;
    assign bus.ext_rdata = bus.dm_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - randomized self-checking bench for dm_arbiter against a transaction model
module tb_dm_arbiter;

    localparam int MAXW = 8;
`ifdef DM_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic mem_clear;
    always #5 clk = ~clk;

    dm_arbiter_if bus ();

    dm_arbiter #(.EXT_MAX_WAIT(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] phys    [1024];
    logic [31:0] ref_mem [1024];

    function automatic logic [31:0] seed_word(input int i);
        return 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Physical memory behind the arbiter: combinational read, write on the edge.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) phys[i] <= seed_word(i);
        end else if (bus.dm_we) begin
            phys[bus.dm_addr[11:2]] <= merge(phys[bus.dm_addr[11:2]], bus.dm_wdata, bus.dm_be);
        end
    end
    assign bus.dm_rdata = phys[bus.dm_addr[11:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_drive(input bit req, input bit we, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a;
        bus.cpu_wdata = d; bus.cpu_be = be;
    endtask

    task automatic ext_drive(input bit req, input bit we, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be, input logic [3:0] len);
        bus.ext_req = req; bus.ext_we = we; bus.ext_addr = a;
        bus.ext_wdata = d; bus.ext_be = be; bus.ext_len = len;
    endtask

    // A CPU access that the model says is performed this cycle.
    task automatic cpu_served(input string tag, input bit req, input bit we,
                              input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (req) begin
            if (we) ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], d, be);
            else    check(tag, bus.cpu_rdata, ref_mem[a[11:2]]);
        end
    endtask

    // One external transaction. mode 0: random CPU traffic, 1: saturated, 2: idle.
    // The grant comes in the first cycle the CPU is idle, or after MAXW waited cycles.
    task automatic run_ext(input int mode, input bit we, input logic [31:0] addr,
                           input logic [3:0] len);
        bit          pat [MAXW+1];
        int          kg, elen;
        bit          h_req, h_we;
        logic [31:0] h_addr, h_data, wd, ea;
        logic [3:0]  be;
        elen = BURST ? int'(len) : 0;
        kg = MAXW;
        for (int k = MAXW; k >= 0; k--) begin
            pat[k] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (!pat[k]) kg = k;
        end
        be     = 4'($urandom_range(1, 15));
        h_req  = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        h_we   = 1'($urandom_range(0, 1));
        h_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        h_data = $urandom;
        for (int c = 0; c <= kg; c++) begin
            bit          cw;
            logic [31:0] ca, cd;
            @(negedge clk);
            cw = 1'($urandom_range(0, 1));
            ca = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            cd = $urandom;
            ext_drive(1'b1, we, addr, $urandom, be, len);
            cpu_drive(pat[c], cw, ca, cd, 4'hF);
            #1;
            check("wait_ack", 32'(bus.ext_ack), 32'd0);
            check("wait_stall", 32'(bus.cpu_stall), 32'd0);
            cpu_served("wait_cpu_rdata", pat[c], cw, ca, cd, 4'hF);
        end
        for (int b = 0; b <= elen; b++) begin
            @(negedge clk);
            wd = $urandom;
            ea = addr + 32'(4 * b);
            ext_drive(1'b1, we, addr, wd, be, len);
            cpu_drive(h_req, h_we, h_addr, h_data, 4'hF);
            #1;
            check("beat_ack", 32'(bus.ext_ack), 32'd1);
            check("beat_last", 32'(bus.ext_last), 32'(b == elen));
            check("beat_addr", bus.dm_addr, ea);
            check("beat_we", 32'(bus.dm_we), 32'(we));
            check("beat_stall", 32'(bus.cpu_stall), 32'(h_req));
            if (we) ref_mem[ea[11:2]] = merge(ref_mem[ea[11:2]], wd, be);
            else    check("beat_rdata", bus.ext_rdata, ref_mem[ea[11:2]]);
        end
        @(negedge clk);
        ext_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        #1;
        check("post_ack", 32'(bus.ext_ack), 32'd0);
        check("post_stall", 32'(bus.cpu_stall), 32'd0);
        cpu_served("post_cpu_rdata", h_req, h_we, h_addr, h_data, 4'hF);
        @(negedge clk);
        cpu_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    initial begin
        int nmis;
        for (int i = 0; i < 1024; i++) ref_mem[i] = seed_word(i);
        mem_clear = 1'b1;
        reset     = 1'b0;
        ext_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        cpu_drive(1'b1, 1'b1, 32'h0000_1234, 32'h5555_AAAA, 4'hF);
        @(negedge clk);
        #1;
        check("rst_stall", 32'(bus.cpu_stall), 32'd0);
        check("rst_ack", 32'(bus.ext_ack), 32'd0);
        check("rst_last", 32'(bus.ext_last), 32'd0);
        check("rst_dm_we", 32'(bus.dm_we), 32'd0);
        check("rst_dm_re", 32'(bus.dm_re), 32'd0);
        check("rst_dm_addr", bus.dm_addr, 32'h0000_1234);
        @(negedge clk);
        mem_clear = 1'b0;
        cpu_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        reset = 1'b1;

        // CPU-only store then load.
        @(negedge clk);
        cpu_drive(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        #1;
        check("cpu_st_stall", 32'(bus.cpu_stall), 32'd0);
        check("cpu_st_we", 32'(bus.dm_we), 32'd1);
        cpu_served("cpu_st", 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        cpu_drive(1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
        #1;
        check("cpu_ld_stall", 32'(bus.cpu_stall), 32'd0);
        check("cpu_ld_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        cpu_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

        run_ext(2, 1'b1, 32'h100, 4'd3);
        run_ext(1, 1'b1, 32'h200, 4'd0);
        run_ext(1, 1'b0, 32'h100, 4'd2);
        run_ext(2, 1'b0, 32'hFFFF_FFF8, 4'd3);
        run_ext(2, 1'b1, 32'h300, 4'd5);
        for (int t = 0; t < 40; t++)
            run_ext(0, 1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 200)),
                    4'($urandom_range(0, 15)));

        // Abort: the request drops after the first beat.
        @(negedge clk);
        ext_drive(1'b1, 1'b1, 32'h400, 32'h0BAD_0BAD, 4'hF, 4'd3);
        #1 check("abt_wait", 32'(bus.ext_ack), 32'd0);
        @(negedge clk);
        #1 check("abt_beat0", 32'(bus.ext_ack), 32'd1);
        ref_mem[10'h100] = 32'h0BAD_0BAD;
        @(negedge clk);
        ext_drive(1'b0, 1'b1, 32'h400, 32'h0BAD_0BAD, 4'hF, 4'd3);
        #1;
        check("abt_drop_ack", 32'(bus.ext_ack), 32'd0);
        check("abt_drop_we", 32'(bus.dm_we), 32'd0);
        @(negedge clk);
        ext_drive(1'b1, 1'b1, 32'h400, 32'h0BAD_0BAD, 4'hF, 4'd3);
        #1 check("abt_regrant_wait", 32'(bus.ext_ack), 32'd0);
        @(negedge clk);
        ext_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        #1 check("abt_idle", 32'(bus.ext_ack), 32'd0);

        // Reset in the middle of an 8-beat write burst.
        @(negedge clk);
        ext_drive(1'b1, 1'b1, 32'h500, 32'h1111_1111, 4'hF, 4'd7);
        #1 check("rmb_wait", 32'(bus.ext_ack), 32'd0);
        @(negedge clk);
        ext_drive(1'b1, 1'b1, 32'h500, 32'h2222_2222, 4'hF, 4'd7);
        #1 check("rmb_beat0", 32'(bus.ext_ack), 32'd1);
        ref_mem[10'h140] = 32'h2222_2222;
        @(negedge clk);
        ext_drive(1'b1, 1'b1, 32'h500, 32'h3333_3333, 4'hF, 4'd7);
        #1 check("rmb_beat1", 32'(bus.ext_ack), 32'(BURST));
        if (BURST) ref_mem[10'h141] = 32'h3333_3333;
        @(negedge clk);
        ext_drive(1'b1, 1'b1, 32'h500, 32'h4444_4444, 4'hF, 4'd7);
        #1;
        check("rmb_pre_we", 32'(bus.dm_we), 32'd1);
        check("rmb_pre_addr", bus.dm_addr, BURST ? 32'h508 : 32'h500);
        #1 reset = 1'b0;
        #1;
        check("rmb_rst_we", 32'(bus.dm_we), 32'd0);
        check("rmb_rst_ack", 32'(bus.ext_ack), 32'd0);
        @(negedge clk);
        ext_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 check("rmb_after_ack", 32'(bus.ext_ack), 32'd0);
        end
        @(negedge clk);
        ext_drive(1'b1, 1'b0, 32'h600, 32'd0, 4'hF, 4'd0);
        #1 check("rmb_new_wait", 32'(bus.ext_ack), 32'd0);
        @(negedge clk);
        #1;
        check("rmb_new_ack", 32'(bus.ext_ack), 32'd1);
        check("rmb_new_addr", bus.dm_addr, 32'h600);
        check("rmb_new_last", 32'(bus.ext_last), 32'd1);
        @(negedge clk);
        ext_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        @(negedge clk);

        nmis = 0;
        for (int i = 0; i < 1024; i++) if (phys[i] !== ref_mem[i]) nmis++;
        check("mem_image_mismatches", 32'(nmis), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
